nibble_serial_adder: RTL



---
 rtl/nibble_serial_adder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice reused once per nibble, LSB first.
// Optional signed-overflow output enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
  parameter int unsigned NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [4*NIB-1:0] sum,
  output logic             cout
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned CW = $clog2(NIB) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic [3:0] g, p, s;
  logic [4:0] c;
  logic       last_nib;

  // Two-level lookahead on the current low nibble of the operand shift registers.
  always_comb begin
    g    = a_q[3:0] & b_q[3:0];
    p    = a_q[3:0] ^ b_q[3:0];
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
  end

  assign last_nib = (cnt_q == CW'(NIB - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        a_d                          = a_q >> 4;
        b_d                          = b_q >> 4;
        sum_d[{cnt_q, 2'b00} +: 4]   = s;
        carry_d                      = c[4];
        if (last_nib) begin
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d   = c[3] ^ c[4];
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
